clb_config_loader: RTL and testbench

Configuration writer for the 4x4 CLB matrix. It accepts a 5-word framed configuration stream over a valid/ready handshake: four 32-bit payload words, then one XOR checksum word. The payload assembles in a shadow register. On a checksum match it commits atomically to the 122-bit configuration bus that drives the CLB's `result_sel`, bypass, operand-select and operation-select inputs. The active configuration never changes mid-load, so the CLB never sees a partially written configuration.

---
 rtl/clb_config_loader.sv | 107 ++++++++++
 tb/tb_clb_config_loader.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/clb_config_loader.sv
// Loads the 122-bit CLB configuration from a framed 5-word stream (4 payload words + XOR checksum).
// A frame reaches the active configuration bus only after its checksum matches, so the bus is never seen half-written.
module clb_config_loader #(
    parameter int CFG_BITS = 122,
    parameter int WORD     = 32
) (
    input  logic                register_clk,
    input  logic                register_reset,
    input  logic                start,
    input  logic                abort,
    input  logic [WORD-1:0]     cfg_word,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    output logic [CFG_BITS-1:0] cfg_out,
    output logic                cfg_loaded,
    output logic                cfg_active,
    output logic                cfg_error,
    output logic                busy
);

    localparam int TOP_BITS = CFG_BITS - 3 * WORD;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state;
    logic [2:0]          word_cnt;
    logic [WORD-1:0]     xor_acc;
    logic [CFG_BITS-1:0] shadow;
    logic                accept;

    // Handshake: a word transfers on a rising edge where cfg_valid and cfg_ready are both high.
    // cfg_ready is a register (high exactly while in LOAD) and never looks at cfg_valid.
    assign accept = cfg_valid & cfg_ready;

    always_ff @(posedge register_clk or posedge register_reset) begin
        if (register_reset) begin
            state      <= IDLE;
            word_cnt   <= 3'd0;
            xor_acc    <= '0;
            shadow     <= '0;
            cfg_out    <= '0;
            cfg_ready  <= 1'b0;
            cfg_loaded <= 1'b0;
            cfg_active <= 1'b0;
            cfg_error  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            cfg_loaded <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= LOAD;
                        word_cnt  <= 3'd0;
                        xor_acc   <= '0;
                        cfg_error <= 1'b0;
                        cfg_ready <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                LOAD: begin
                    if (abort) begin
                        state     <= IDLE;
                        cfg_ready <= 1'b0;
                        busy      <= 1'b0;
                    end else if (accept) begin
                        if (word_cnt == 3'd4) begin
                            cfg_ready <= 1'b0;
                            busy      <= 1'b0;
                            if (cfg_word == xor_acc) begin
                                cfg_out    <= shadow;
                                cfg_active <= 1'b1;
                                cfg_loaded <= 1'b1;
                                state      <= DONE;
                            end else begin
                                cfg_error <= 1'b1;
                                state     <= IDLE;
                            end
                        end else begin
                            // Word 3 only carries 26 live bits; its upper bits still feed the checksum.
                            case (word_cnt[1:0])
                                2'd0:    shadow[0*WORD +: WORD]        <= cfg_word;
                                2'd1:    shadow[1*WORD +: WORD]        <= cfg_word;
                                2'd2:    shadow[2*WORD +: WORD]        <= cfg_word;
                                default: shadow[CFG_BITS-1:3*WORD]     <= cfg_word[TOP_BITS-1:0];
                            endcase
                            xor_acc  <= xor_acc ^ cfg_word;
                            word_cnt <= word_cnt + 3'd1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state     <= IDLE;
                    cfg_ready <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clb_config_loader.sv
// Directed bench for clb_config_loader: a table of whole frames plus hand-written
// sequences for reset, abort, ignored controls and the DONE cycle.
module tb_clb_config_loader;

    logic         register_clk = 1'b0;
    logic         register_reset = 1'b1;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic [31:0]  cfg_word = 32'h0;
    logic         cfg_valid = 1'b0;
    logic         cfg_ready;
    logic [121:0] cfg_out;
    logic         cfg_loaded;
    logic         cfg_active;
    logic         cfg_error;
    logic         busy;

    int compared = 0;
    int mismatched = 0;
    logic [121:0] model_cfg = '0;

    typedef struct packed {
        logic [4:0][31:0] w;
        logic             bubbles;
        logic [121:0]     exp_out;
        logic             exp_err;
    } vec_t;

    vec_t vecs [6];

    localparam logic [121:0] CFG_A = 122'h3FFFFFF_44444444_22222222_11111111;
    localparam logic [121:0] CFG_B = 122'h0000000_A5A5A5A5_12345678_DEADBEEF;
    localparam logic [121:0] CFG_C = 122'h1234567_0000FFFF_80000000_00000001;

    clb_config_loader #(.CFG_BITS(122), .WORD(32)) dut (
        .register_clk   (register_clk),
        .register_reset (register_reset),
        .start          (start),
        .abort          (abort),
        .cfg_word       (cfg_word),
        .cfg_valid      (cfg_valid),
        .cfg_ready      (cfg_ready),
        .cfg_out        (cfg_out),
        .cfg_loaded     (cfg_loaded),
        .cfg_active     (cfg_active),
        .cfg_error      (cfg_error),
        .busy           (busy)
    );

    always #5 register_clk = ~register_clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic send_word(input logic [31:0] w);
        @(negedge register_clk);
        cfg_valid = 1'b1;
        cfg_word  = w;
        @(posedge register_clk);
        #1;
    endtask

    task automatic pulse_start();
        @(negedge register_clk);
        start = 1'b1;
        @(posedge register_clk);
        #1;
        @(negedge register_clk);
        start = 1'b0;
    endtask

    // One complete frame from the table: start, 5 words (optionally with bubbles), then the result checks.
    task automatic run_frame(input vec_t v, input string tag);
        int n;
        @(negedge register_clk);
        start = 1'b1;
        @(posedge register_clk);
        #1;
        check({tag, "_ready_after_start"}, cfg_ready, 1'b1);
        check({tag, "_busy_after_start"}, busy, 1'b1);
        check({tag, "_error_cleared"}, cfg_error, 1'b0);
        @(negedge register_clk);
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (v.bubbles) begin
                n = $urandom_range(0, 3);
                repeat (n) begin
                    @(negedge register_clk);
                    cfg_valid = 1'b0;
                    cfg_word  = $urandom;
                    @(posedge register_clk);
                    #1;
                    check({tag, "_bubble_cnt"}, dut.word_cnt, i);
                end
            end
            send_word(v.w[i]);
            if (i < 4) begin
                check({tag, "_ready_mid"}, cfg_ready, 1'b1);
                check({tag, "_out_mid"}, cfg_out, model_cfg);
            end
        end
        check({tag, "_out"}, cfg_out, v.exp_out);
        check({tag, "_loaded"}, cfg_loaded, !v.exp_err);
        check({tag, "_error"}, cfg_error, v.exp_err);
        check({tag, "_active"}, cfg_active, 1'b1);
        check({tag, "_ready_end"}, cfg_ready, 1'b0);
        @(negedge register_clk);
        cfg_valid = 1'b0;
        @(posedge register_clk);
        #1;
        check({tag, "_loaded_drop"}, cfg_loaded, 1'b0);
        check({tag, "_busy_end"}, busy, 1'b0);
        model_cfg = v.exp_out;
    endtask

    task automatic summary();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    endtask

    initial begin
        #200000;
        mismatched++;
        $display("FAIL watchdog: time limit reached, expected bench to finish");
        summary();
        $finish;
    end

    initial begin
        vecs[0] = '{w: {32'h74888888, 32'h03FFFFFF, 32'h44444444, 32'h22222222, 32'h11111111},
                    bubbles: 1'b0, exp_out: CFG_A, exp_err: 1'b0};
        vecs[1] = '{w: {32'h00000000, 32'h03FFFFFF, 32'h44444444, 32'h22222222, 32'h11111111},
                    bubbles: 1'b0, exp_out: CFG_A, exp_err: 1'b1};
        vecs[2] = '{w: {32'h953C4D32, 32'hFC000000, 32'hA5A5A5A5, 32'h12345678, 32'hDEADBEEF},
                    bubbles: 1'b0, exp_out: CFG_B, exp_err: 1'b0};
        vecs[3] = '{w: {32'h74888888, 32'h03FFFFFF, 32'h44444444, 32'h22222222, 32'h11111111},
                    bubbles: 1'b1, exp_out: CFG_A, exp_err: 1'b0};
        vecs[4] = '{w: {32'h8123BA99, 32'h01234567, 32'h0000FFFF, 32'h80000000, 32'h00000001},
                    bubbles: 1'b1, exp_out: CFG_C, exp_err: 1'b0};
        vecs[5] = '{w: {32'h8123BA98, 32'h01234567, 32'h0000FFFF, 32'h80000000, 32'h00000001},
                    bubbles: 1'b0, exp_out: CFG_C, exp_err: 1'b1};

        // Reset state while reset is held.
        #3;
        check("rst_out", cfg_out, 122'h0);
        check("rst_ready", cfg_ready, 1'b0);
        check("rst_loaded", cfg_loaded, 1'b0);
        check("rst_active", cfg_active, 1'b0);
        check("rst_error", cfg_error, 1'b0);
        check("rst_busy", busy, 1'b0);
        @(negedge register_clk);
        register_reset = 1'b0;
        @(negedge register_clk);

        for (int k = 0; k < 6; k++)
            run_frame(vecs[k], $sformatf("vec%0d", k));

        // Abort after two words, coincident with a valid word.
        pulse_start();
        send_word(32'h11111111);
        send_word(32'h22222222);
        @(negedge register_clk);
        abort     = 1'b1;
        cfg_valid = 1'b1;
        cfg_word  = 32'h44444444;
        @(posedge register_clk);
        #1;
        check("abort_busy", busy, 1'b0);
        check("abort_ready", cfg_ready, 1'b0);
        check("abort_out", cfg_out, model_cfg);
        check("abort_error", cfg_error, 1'b0);
        check("abort_loaded", cfg_loaded, 1'b0);
        @(negedge register_clk);
        abort     = 1'b0;
        cfg_valid = 1'b0;
        run_frame(vecs[0], "after_abort");

        // start during LOAD must not restart the frame.
        pulse_start();
        send_word(32'h00000001);
        send_word(32'h80000000);
        @(negedge register_clk);
        cfg_valid = 1'b0;
        start     = 1'b1;
        @(posedge register_clk);
        #1;
        check("start_in_load_cnt", dut.word_cnt, 3'd2);
        check("start_in_load_busy", busy, 1'b1);
        @(negedge register_clk);
        start = 1'b0;
        send_word(32'h0000FFFF);
        send_word(32'h01234567);
        send_word(32'h8123BA99);
        check("start_in_load_out", cfg_out, CFG_C);
        check("start_in_load_loaded", cfg_loaded, 1'b1);
        model_cfg = CFG_C;

        // start and abort during DONE are both ignored.
        @(negedge register_clk);
        cfg_valid = 1'b0;
        start     = 1'b1;
        abort     = 1'b1;
        @(posedge register_clk);
        #1;
        check("done_start_busy", busy, 1'b0);
        check("done_start_ready", cfg_ready, 1'b0);
        check("done_loaded_drop", cfg_loaded, 1'b0);
        @(negedge register_clk);
        start = 1'b0;
        abort = 1'b0;

        // cfg_valid in IDLE does nothing.
        @(negedge register_clk);
        cfg_valid = 1'b1;
        cfg_word  = 32'hFFFFFFFF;
        @(posedge register_clk);
        #1;
        check("idle_valid_busy", busy, 1'b0);
        check("idle_valid_out", cfg_out, model_cfg);
        @(negedge register_clk);
        cfg_valid = 1'b0;

        // Asynchronous reset in the middle of a frame, between clock edges.
        pulse_start();
        send_word(32'h11111111);
        send_word(32'h22222222);
        @(negedge register_clk);
        cfg_valid = 1'b0;
        #2;
        register_reset = 1'b1;
        #1;
        check("async_rst_out", cfg_out, 122'h0);
        check("async_rst_ready", cfg_ready, 1'b0);
        check("async_rst_busy", busy, 1'b0);
        check("async_rst_active", cfg_active, 1'b0);
        check("async_rst_loaded", cfg_loaded, 1'b0);
        check("async_rst_error", cfg_error, 1'b0);
        @(negedge register_clk);
        register_reset = 1'b0;
        model_cfg = '0;
        run_frame(vecs[2], "after_rst");

        summary();
        $finish;
    end

endmodule
